// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the IF stage: FSM states, bubble word, JAL opcode
// and the J-type immediate decoder.
package if_fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } if_state_t;

    localparam logic [31:0] BUBBLE_INST_DEFAULT = 32'h0000_0000;
    localparam logic [6:0]  OPCODE_JAL          = 7'b1101111;

    function automatic logic [31:0] j_imm(input logic [31:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/if_fetch_stage_buffer.sv
// One-entry instruction/PC holding register used while ID is stalled.
// Priority: clear over load over drain.
module if_fetch_buffer
    import if_fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        load,
    input  logic        drain,
    input  logic [31:0] load_inst,
    input  logic [31:0] load_pc,
    output logic        full,
    output logic [31:0] inst,
    output logic [31:0] pc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full <= 1'b0;
            inst <= '0;
            pc   <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            inst <= load_inst;
            pc   <= load_pc;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: PC, single-outstanding imem handshake,
// response buffer and IF/ID register. Optional JAL prediction: IF_JAL_PREDICT_EN.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_INST = BUBBLE_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4
);

    if_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q;
    logic [31:0] redir_pc;
    logic        handshake;
    logic        resp;

    logic        buf_full, buf_load, buf_drain;
    logic [31:0] buf_inst, buf_pc;

    logic        id_valid_d;
    logic [31:0] id_inst_d, id_pc_d, id_pc4_d;

    assign redir_pc  = redirect_pc & ~32'h3;
    assign imem_addr = pc_q;
    assign handshake = (state_q == ST_REQ) && imem_ready;
    // A full buffer in WAIT means the response already arrived; rvalid is then spurious.
    assign resp      = (state_q == ST_WAIT) && imem_rvalid && !buf_full;

    if_fetch_buffer u_buf (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect),
        .load      (buf_load),
        .drain     (buf_drain),
        .load_inst (imem_rdata),
        .load_pc   (req_addr_q),
        .full      (buf_full),
        .inst      (buf_inst),
        .pc        (buf_pc)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        imem_req  = 1'b0;
        buf_load  = !redirect && stall && resp;
        buf_drain = !redirect && !stall && buf_full;

        case (state_q)
            ST_BOOT:  state_d = ST_REQ;
            ST_REQ: begin
                imem_req = 1'b1;
                if (imem_ready)
                    state_d = redirect ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                if (redirect)
                    state_d = (imem_rvalid || buf_full) ? ST_REQ : ST_DRAIN;
                else if (buf_full || resp)
                    state_d = stall ? ST_WAIT : ST_REQ;
            end
            ST_DRAIN: begin
                if (imem_rvalid)
                    state_d = ST_REQ;
            end
            default:  state_d = ST_BOOT;
        endcase

        if (redirect)
            pc_d = redir_pc;
        else if (handshake)
            pc_d = pc_q + 32'd4;
`ifdef IF_JAL_PREDICT_EN
        else if (resp && imem_rdata[6:0] == OPCODE_JAL)
            pc_d = (req_addr_q + j_imm(imem_rdata)) & ~32'h3;
`endif
    end

    always_comb begin
        id_valid_d = id_valid;
        id_inst_d  = id_inst;
        id_pc_d    = id_pc;
        id_pc4_d   = id_pc4;
        if (redirect || (!stall && !buf_full && !resp)) begin
            id_valid_d = 1'b0;
            id_inst_d  = BUBBLE_INST;
        end else if (!stall && buf_full) begin
            id_valid_d = 1'b1;
            id_inst_d  = buf_inst;
            id_pc_d    = buf_pc;
            id_pc4_d   = buf_pc + 32'd4;
        end else if (!stall) begin
            id_valid_d = 1'b1;
            id_inst_d  = imem_rdata;
            id_pc_d    = req_addr_q;
            id_pc4_d   = req_addr_q + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC & ~32'h3;
            req_addr_q <= '0;
            id_valid   <= 1'b0;
            id_inst    <= BUBBLE_INST;
            id_pc      <= '0;
            id_pc4     <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            id_valid <= id_valid_d;
            id_inst  <= id_inst_d;
            id_pc    <= id_pc_d;
            id_pc4   <= id_pc4_d;
            if (handshake)
                req_addr_q <= pc_q;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage; the JAL-prediction test
// is built only when IF_JAL_PREDICT_EN is defined.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, imem_ready, imem_rvalid, stall, redirect;
    logic [31:0] imem_rdata, redirect_pc;
    logic        imem_req, id_valid;
    logic [31:0] imem_addr, id_inst, id_pc, id_pc4;

    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;

    logic        auto_resp;
    logic        ov_en;
    logic [31:0] ov_addr, ov_data;

    if_fetch_stage #(.RESET_PC(32'h0000_0100), .BUBBLE_INST(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_pc4(id_pc4)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (ov_en && a == ov_addr) return ov_data;
        return (a << 8) | 32'h0000_0013;
    endfunction

    // Advances one clock; the memory model answers accepted requests one cycle later.
    task automatic step();
        logic        acc;
        logic [31:0] a;
        acc = imem_req && imem_ready;
        a   = imem_addr;
        @(posedge clk);
        #1;
        if (auto_resp) begin
            imem_rvalid = acc;
            imem_rdata  = acc ? mem_word(a) : 32'h0;
        end
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin
                ok = 1'b1;
                return;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        auto_resp = 1'b1; ov_en = 1'b0; ov_addr = '0; ov_data = '0;
        step(); step();
        tests_run++;
        if (imem_req !== 1'b0 || id_valid !== 1'b0 || id_inst !== 32'h0 ||
            id_pc !== 32'h0 || id_pc4 !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_state: req=%b valid=%b inst=%h pc=%h pc4=%h, required 0 0 0 0 0",
                     imem_req, id_valid, id_inst, id_pc, id_pc4);
        end
        reset = 1'b0;
        tests_run++;
        if (imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL boot_no_req: req=%b required 0", imem_req);
        end
    endtask

    task automatic test_fetch_seq();
        bit          ok;
        logic [31:0] a;
        for (int i = 0; i < 3; i++) begin
            a = 32'h100 + 32'(4 * i);
            wait_req(ok);
            tests_run++;
            if (!ok || imem_addr !== a) begin
                tests_failed++;
                $display("FAIL fetch_addr%0d: ok=%b addr=%h required %h", i, ok, imem_addr, a);
            end
            if (i == 0) begin
                tests_run++;
                if (id_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL first_invalid: id_valid=%b required 0", id_valid);
                end
            end
            step(); step();
            tests_run++;
            if (id_valid !== 1'b1 || id_inst !== mem_word(a) || id_pc !== a || id_pc4 !== a + 32'd4) begin
                tests_failed++;
                $display("FAIL fetch_id%0d: valid=%b inst=%h pc=%h pc4=%h required 1 %h %h %h",
                         i, id_valid, id_inst, id_pc, id_pc4, mem_word(a), a, a + 32'd4);
            end
        end
    endtask

    task automatic test_stall();
        ov_en = 1'b1; ov_addr = 32'h10C; ov_data = 32'h0050_0093;
        stall = 1'b1;
        step();
        tests_run++;
        if (id_valid !== 1'b1 || id_inst !== 32'h0001_0813 || id_pc !== 32'h108) begin
            tests_failed++;
            $display("FAIL stall_hold1: valid=%b inst=%h pc=%h required 1 00010813 00000108",
                     id_valid, id_inst, id_pc);
        end
        step(); step();
        tests_run++;
        if (id_valid !== 1'b1 || id_inst !== 32'h0001_0813 || imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_hold3: valid=%b inst=%h req=%b required 1 00010813 0",
                     id_valid, id_inst, imem_req);
        end
        stall = 1'b0;
        step();
        tests_run++;
        if (id_valid !== 1'b1 || id_inst !== 32'h0050_0093 || id_pc !== 32'h10C || id_pc4 !== 32'h110) begin
            tests_failed++;
            $display("FAIL stall_release: valid=%b inst=%h pc=%h pc4=%h required 1 00500093 0000010c 00000110",
                     id_valid, id_inst, id_pc, id_pc4);
        end
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h110) begin
            tests_failed++;
            $display("FAIL stall_next_addr: req=%b addr=%h required 1 00000110", imem_req, imem_addr);
        end
        ov_en = 1'b0;
        step(); step();
        tests_run++;
        if (id_valid !== 1'b1 || id_inst !== 32'h0001_1013 || id_pc !== 32'h110) begin
            tests_failed++;
            $display("FAIL stall_after: valid=%b inst=%h pc=%h required 1 00011013 00000110",
                     id_valid, id_inst, id_pc);
        end
    endtask

    task automatic test_redirect_wait();
        auto_resp = 1'b0; imem_rvalid = 1'b0;
        step();
        redirect = 1'b1; redirect_pc = 32'h201;
        step();
        redirect = 1'b0;
        tests_run++;
        if (id_valid !== 1'b0 || id_inst !== 32'h0 || imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL redir_flush: valid=%b inst=%h req=%b required 0 0 0", id_valid, id_inst, imem_req);
        end
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        tests_run++;
        if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            tests_failed++;
            $display("FAIL redir_drain: valid=%b req=%b addr=%h required 0 1 00000200",
                     id_valid, imem_req, imem_addr);
        end
        auto_resp = 1'b1;
        step(); step();
        tests_run++;
        if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_inst !== 32'h0002_0013) begin
            tests_failed++;
            $display("FAIL redir_target: valid=%b pc=%h inst=%h required 1 00000200 00020013",
                     id_valid, id_pc, id_inst);
        end
    endtask

    task automatic test_redirect_rvalid_stall();
        auto_resp = 1'b0; imem_rvalid = 1'b0;
        step();
        redirect = 1'b1; redirect_pc = 32'h300; stall = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        redirect = 1'b0; stall = 1'b0; imem_rvalid = 1'b0;
        tests_run++;
        if (id_valid !== 1'b0 || id_inst !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            tests_failed++;
            $display("FAIL redir_same_cycle: valid=%b inst=%h req=%b addr=%h required 0 0 1 00000300",
                     id_valid, id_inst, imem_req, imem_addr);
        end
        auto_resp = 1'b1;
        step(); step();
        tests_run++;
        if (id_valid !== 1'b1 || id_pc !== 32'h300 || id_inst !== 32'h0003_0013) begin
            tests_failed++;
            $display("FAIL redir_same_target: valid=%b pc=%h inst=%h required 1 00000300 00030013",
                     id_valid, id_pc, id_inst);
        end
    endtask

    task automatic test_ready_low();
        imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            tests_run++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h304) begin
                tests_failed++;
                $display("FAIL ready_low%0d: req=%b addr=%h required 1 00000304", i, imem_req, imem_addr);
            end
        end
        imem_ready = 1'b1;
        step(); step();
        tests_run++;
        if (id_valid !== 1'b1 || id_pc !== 32'h304 || id_inst !== 32'h0003_0413) begin
            tests_failed++;
            $display("FAIL ready_resume: valid=%b pc=%h inst=%h required 1 00000304 00030413",
                     id_valid, id_pc, id_inst);
        end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        step();
        tests_run++;
        if (id_valid !== 1'b0 || imem_addr !== 32'hFFFF_FFFC || imem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_addr: valid=%b req=%b addr=%h required 0 1 fffffffc", id_valid, imem_req, imem_addr);
        end
        step(); step();
        tests_run++;
        if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC || id_pc4 !== 32'h0) begin
            tests_failed++;
            $display("FAIL wrap_pc4: valid=%b pc=%h pc4=%h required 1 fffffffc 00000000", id_valid, id_pc, id_pc4);
        end
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL wrap_next: req=%b addr=%h required 1 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_reset_mid();
        step();
        #1 reset = 1'b1;
        #1;
        tests_run++;
        if (imem_req !== 1'b0 || id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mid: req=%b valid=%b pc=%h inst=%h required 0 0 0 0", imem_req, id_valid, id_pc, id_inst);
        end
        imem_rvalid = 1'b0;
        step();
        reset = 1'b0;
        step();
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            tests_failed++;
            $display("FAIL reset_mid_restart: req=%b addr=%h required 1 00000100", imem_req, imem_addr);
        end
    endtask

`ifdef IF_JAL_PREDICT_EN
    task automatic test_jal_predict();
        ov_en = 1'b1; ov_addr = 32'h0; ov_data = 32'h0100_006F;
        redirect = 1'b1; redirect_pc = 32'h0;
        step();
        redirect = 1'b0;
        step(); step(); step();
        tests_run++;
        if (id_inst !== 32'h0100_006F || imem_req !== 1'b1 || imem_addr !== 32'h10) begin
            tests_failed++;
            $display("FAIL jal_fwd: inst=%h req=%b addr=%h required 0100006f 1 00000010", id_inst, imem_req, imem_addr);
        end
        ov_data = 32'hFFDF_F06F;
        redirect = 1'b1; redirect_pc = 32'h0;
        step();
        redirect = 1'b0;
        step(); step(); step();
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            tests_failed++;
            $display("FAIL jal_back: req=%b addr=%h required 1 fffffffc", imem_req, imem_addr);
        end
        step(); step();
        tests_run++;
        if (id_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL jal_wrap: pc=%h addr=%h required fffffffc 00000000", id_pc, imem_addr);
        end
        ov_en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_fetch_seq();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid_stall();
        test_ready_low();
        test_wrap();
        test_reset_mid();
`ifdef IF_JAL_PREDICT_EN
        test_jal_predict();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
